// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the native memory bus, with a per-transaction
// watchdog that answers the owning master with an error if the slave never responds.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout_pulse
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        last_grant;
    logic        owner;
    logic        win;
    logic        any_req;
    logic        timeout;
    logic        req_instr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [15:0] cnt;

    // Tie goes to the master that did not own the bus last.
    always_comb begin
        any_req = m0_valid | m1_valid;
        win     = (m0_valid && m1_valid) ? ~last_grant : m1_valid;
        timeout = (cnt == 16'(TIMEOUT_CYCLES - 1)) && !s_ready;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = BUSY;
            BUSY:    if (s_ready || timeout) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            req_instr  <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_wstrb  <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (any_req) begin
                        owner      <= win;
                        last_grant <= win;
                        req_instr  <= win ? m1_instr : m0_instr;
                        req_addr   <= win ? m1_addr  : m0_addr;
                        req_wdata  <= win ? m1_wdata : m0_wdata;
                        req_wstrb  <= win ? m1_wstrb : m0_wstrb;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 16'd1;
                    // A ready arriving on the timeout cycle still counts as a normal completion.
                    if (s_ready) begin
                        rdata_q <= s_rdata;
                        err_q   <= 1'b0;
                    end else if (timeout) begin
                        rdata_q <= ERR_DATA;
                        err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        s_valid       = (state == BUSY);
        s_instr       = req_instr;
        s_addr        = req_addr;
        s_wdata       = req_wdata;
        s_wstrb       = req_wstrb;
        m0_ready      = (state == RESP) && !owner;
        m1_ready      = (state == RESP) && owner;
        m0_err        = m0_ready && err_q;
        m1_err        = m1_ready && err_q;
        m0_rdata      = m0_ready ? rdata_q : '0;
        m1_rdata      = m1_ready ? rdata_q : '0;
        grant         = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
        timeout_pulse = (state == RESP) && err_q;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a scoreboard of expected {err, rdata}
// per master plus inline checks of grant order, latency and watchdog behaviour.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_valid, m0_instr, m0_ready, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_instr, m1_ready, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        s_valid, s_instr, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;
    logic        timeout_pulse;

    int          checks;
    int          failures;
    int          slave_lat;
    int          busy;
    logic [31:0] rd_key;
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic [1:0]  gq[$];

    mem_bus_arbiter #(.TIMEOUT_CYCLES(16), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .timeout_pulse(timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and let the slave model react; slave_lat = BUSY cycle that sees ready, 0 = never.
    task automatic tick();
        @(posedge clk);
        #1;
        if (s_valid) begin
            busy++;
            s_ready = (slave_lat != 0) && (busy == slave_lat);
            s_rdata = s_ready ? (s_addr ^ rd_key) : 32'h0;
        end else begin
            busy    = 0;
            s_ready = 1'b0;
            s_rdata = 32'h0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0;
        tick(); tick();
        checks++;
        if ({s_valid, s_instr, s_addr, s_wdata, s_wstrb} !== 70'h0) begin
            failures++; $display("FAIL reset_s_bus: got %h expected 0", {s_valid, s_instr, s_addr, s_wdata, s_wstrb});
        end
        checks++;
        if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant: got %b expected 00", grant); end
        checks++;
        if ({m0_ready, m1_ready, m0_err, m1_err, timeout_pulse} !== 5'b0) begin
            failures++; $display("FAIL reset_flags: got %b expected 00000", {m0_ready, m1_ready, m0_err, m1_err, timeout_pulse});
        end
        checks++;
        if ({m0_rdata, m1_rdata} !== 64'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", {m0_rdata, m1_rdata}); end
        rst_n = 1'b1;
        tick();
        checks++;
        if (s_valid !== 1'b0) begin failures++; $display("FAIL idle_no_req: s_valid got %b expected 0", s_valid); end
    endtask

    task automatic test_single_read();
        int n;
        logic [32:0] e;
        slave_lat = 1; rd_key = 32'h1234_5668;
        m0_valid = 1'b1; m0_instr = 1'b0; m0_addr = 32'h10; m0_wdata = 32'h0; m0_wstrb = 4'h0;
        q0.push_back({1'b0, 32'h1234_5678});
        tick();
        checks++;
        if ({s_valid, grant, s_addr} !== {1'b1, 2'b01, 32'h10}) begin
            failures++; $display("FAIL single_req: got %h expected %h", {s_valid, grant, s_addr}, {1'b1, 2'b01, 32'h10});
        end
        n = 1;
        while (!m0_ready && n < 10) begin tick(); n++; end
        checks++;
        if (n !== 2 || m0_ready !== 1'b1) begin failures++; $display("FAIL single_latency: ready after %0d ticks expected 2", n); end
        if (m0_ready === 1'b1) begin
            e = q0.pop_front();
            checks++;
            if ({m0_err, m0_rdata} !== e) begin failures++; $display("FAIL single_data: got %h expected %h", {m0_err, m0_rdata}, e); end
        end
        m0_valid = 1'b0;
        tick();
        checks++;
        if ({m0_ready, m1_ready} !== 2'b00) begin failures++; $display("FAIL single_pulse: got %b expected 00", {m0_ready, m1_ready}); end
    endtask

    task automatic test_simultaneous();
        logic d0, d1, early, saw_write;
        logic [32:0] e;
        do_reset();
        slave_lat = 1; rd_key = 32'h0;
        m0_valid = 1'b1; m0_addr = 32'h20; m0_wstrb = 4'h0; m0_wdata = 32'h0;
        m1_valid = 1'b1; m1_addr = 32'h40; m1_wstrb = 4'hF; m1_wdata = 32'hA5A5_A5A5; m1_instr = 1'b0;
        q0.push_back({1'b0, 32'h20});
        q1.push_back({1'b0, 32'h40});
        tick();
        checks++;
        if ({grant, s_addr} !== {2'b01, 32'h20}) begin failures++; $display("FAIL tie_first: got %h expected %h", {grant, s_addr}, {2'b01, 32'h20}); end
        d0 = 0; d1 = 0; early = 0; saw_write = 0;
        for (int i = 0; i < 20 && !(d0 && d1); i++) begin
            if (s_valid && s_wstrb == 4'hF) begin
                if (!d0) early = 1;
                if (s_wdata == 32'hA5A5_A5A5 && s_addr == 32'h40 && grant == 2'b10) saw_write = 1;
            end
            if (m0_ready) begin
                e = q0.pop_front(); checks++;
                if ({m0_err, m0_rdata} !== e) begin failures++; $display("FAIL tie_m0_data: got %h expected %h", {m0_err, m0_rdata}, e); end
                m0_valid = 1'b0; d0 = 1;
            end
            if (m1_ready) begin
                e = q1.pop_front(); checks++;
                if ({m1_err, m1_rdata} !== e) begin failures++; $display("FAIL tie_m1_data: got %h expected %h", {m1_err, m1_rdata}, e); end
                m1_valid = 1'b0; d1 = 1;
            end
            tick();
        end
        checks++;
        if ({d0, d1, early, saw_write} !== 4'b1101) begin
            failures++; $display("FAIL tie_order: got done0/done1/early/write=%b expected 1101", {d0, d1, early, saw_write});
        end
    endtask

    task automatic test_fairness();
        int s0, s1, i0, i1;
        logic [32:0] e;
        logic [1:0] g;
        do_reset();
        slave_lat = 2; rd_key = 32'hC0DE_0000;
        for (int k = 0; k < 4; k++) begin gq.push_back(2'b01); gq.push_back(2'b10); end
        m0_valid = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'h0;
        m1_valid = 1'b1; m1_addr = 32'h200; m1_wstrb = 4'h0;
        q0.push_back({1'b0, 32'h100 ^ rd_key});
        q1.push_back({1'b0, 32'h200 ^ rd_key});
        s0 = 0; s1 = 0; i0 = 1; i1 = 1;
        for (int i = 0; i < 100 && (s0 + s1) < 8; i++) begin
            tick();
            if (m0_ready || m1_ready) begin
                g = (gq.size() > 0) ? gq.pop_front() : 2'b11;
                checks++;
                if (grant !== g) begin failures++; $display("FAIL fair_grant: got %b expected %b", grant, g); end
            end
            if (m0_ready) begin
                e = q0.pop_front(); checks++; s0++;
                if ({m0_err, m0_rdata} !== e) begin failures++; $display("FAIL fair_m0_data: got %h expected %h", {m0_err, m0_rdata}, e); end
                if (i0 < 4) begin m0_addr = 32'h100 + 32'(16 * i0); q0.push_back({1'b0, m0_addr ^ rd_key}); i0++; end
                else m0_valid = 1'b0;
            end
            if (m1_ready) begin
                e = q1.pop_front(); checks++; s1++;
                if ({m1_err, m1_rdata} !== e) begin failures++; $display("FAIL fair_m1_data: got %h expected %h", {m1_err, m1_rdata}, e); end
                if (i1 < 4) begin m1_addr = 32'h200 + 32'(16 * i1); q1.push_back({1'b0, m1_addr ^ rd_key}); i1++; end
                else m1_valid = 1'b0;
            end
        end
        checks++;
        if (s0 !== 4 || s1 !== 4) begin failures++; $display("FAIL fair_count: got m0=%0d m1=%0d expected 4 4", s0, s1); end
        tick();
    endtask

    task automatic test_timeout();
        int sv, pulses;
        logic [32:0] e;
        slave_lat = 0;
        m1_valid = 1'b1; m1_addr = 32'h80; m1_wstrb = 4'h0;
        q1.push_back({1'b1, 32'hDEAD_BEEF});
        sv = 0; pulses = 0;
        for (int i = 0; i < 40 && !m1_ready; i++) begin
            tick();
            if (s_valid) sv++;
            if (timeout_pulse) pulses++;
        end
        checks++;
        if ({m1_ready, m0_ready} !== 2'b10) begin failures++; $display("FAIL to_ready: got %b expected 10", {m1_ready, m0_ready}); end
        if (m1_ready === 1'b1) begin
            e = q1.pop_front(); checks++;
            if ({m1_err, m1_rdata} !== e) begin failures++; $display("FAIL to_data: got %h expected %h", {m1_err, m1_rdata}, e); end
        end
        checks++;
        if (sv !== 16) begin failures++; $display("FAIL to_busy_len: got %0d expected 16", sv); end
        m1_valid = 1'b0;
        tick();
        if (timeout_pulse) pulses++;
        checks++;
        if (pulses !== 1) begin failures++; $display("FAIL to_pulses: got %0d expected 1", pulses); end
    endtask

    task automatic test_timeout_race();
        int sv, pulses;
        logic [32:0] e;
        slave_lat = 16; rd_key = 32'h0BAD_F00D;
        m0_valid = 1'b1; m0_addr = 32'h44; m0_wstrb = 4'h0;
        q0.push_back({1'b0, 32'h44 ^ 32'h0BAD_F00D});
        sv = 0; pulses = 0;
        for (int i = 0; i < 40 && !m0_ready; i++) begin
            tick();
            if (s_valid) sv++;
            if (timeout_pulse) pulses++;
        end
        checks++;
        if (m0_ready !== 1'b1) begin failures++; $display("FAIL race_ready: got %b expected 1", m0_ready); end
        if (m0_ready === 1'b1) begin
            e = q0.pop_front(); checks++;
            if ({m0_err, m0_rdata} !== e) begin failures++; $display("FAIL race_data: got %h expected %h", {m0_err, m0_rdata}, e); end
        end
        m0_valid = 1'b0;
        tick();
        if (timeout_pulse) pulses++;
        checks++;
        if (sv !== 16 || pulses !== 0) begin failures++; $display("FAIL race_timing: got busy=%0d pulses=%0d expected 16 0", sv, pulses); end
    endtask

    task automatic test_reset_mid();
        logic d0, d1, rdy_in_rst;
        logic [32:0] e;
        slave_lat = 0;
        m0_valid = 1'b1; m0_addr = 32'h90; m0_wstrb = 4'h0;
        tick(); tick(); tick();
        checks++;
        if ({s_valid, grant} !== 3'b101) begin failures++; $display("FAIL mid_busy: got %b expected 101", {s_valid, grant}); end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({s_valid, grant, m0_ready, m1_ready, m0_err, m1_err, timeout_pulse, s_addr, m0_rdata, m1_rdata} !== 104'h0) begin
            failures++; $display("FAIL mid_reset_outputs: got nonzero outputs, s_valid=%b grant=%b s_addr=%h", s_valid, grant, s_addr);
        end
        rdy_in_rst = m0_ready | m1_ready;
        tick();
        rdy_in_rst = rdy_in_rst | m0_ready | m1_ready;
        checks++;
        if (rdy_in_rst !== 1'b0) begin failures++; $display("FAIL mid_no_ready: got %b expected 0", rdy_in_rst); end
        rst_n = 1'b1; slave_lat = 1; rd_key = 32'h0;
        m1_valid = 1'b1; m1_addr = 32'h34; m1_wstrb = 4'h0;
        q0.delete(); q1.delete();
        q0.push_back({1'b0, 32'h90});
        q1.push_back({1'b0, 32'h34});
        tick();
        checks++;
        if ({grant, s_addr} !== {2'b01, 32'h90}) begin failures++; $display("FAIL mid_tie_after_reset: got %h expected %h", {grant, s_addr}, {2'b01, 32'h90}); end
        d0 = 0; d1 = 0;
        for (int i = 0; i < 20 && !(d0 && d1); i++) begin
            if (m0_ready) begin
                e = q0.pop_front(); checks++;
                if ({m0_err, m0_rdata} !== e) begin failures++; $display("FAIL mid_m0_data: got %h expected %h", {m0_err, m0_rdata}, e); end
                m0_valid = 1'b0; d0 = 1;
            end
            if (m1_ready) begin
                e = q1.pop_front(); checks++;
                if ({m1_err, m1_rdata} !== e) begin failures++; $display("FAIL mid_m1_data: got %h expected %h", {m1_err, m1_rdata}, e); end
                m1_valid = 1'b0; d1 = 1;
            end
            tick();
        end
        checks++;
        if ({d0, d1} !== 2'b11) begin failures++; $display("FAIL mid_drain: got %b expected 11", {d0, d1}); end
    endtask

    initial begin
        checks = 0; failures = 0; slave_lat = 0; busy = 0; rd_key = 32'h0;
        rst_n = 1'b0; s_ready = 1'b0; s_rdata = 32'h0;
        m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
        m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_fairness();
        test_timeout();
        test_timeout_race();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
